xor_fold_stream: RTL
====================

// Module: xor_fold_stream
// PURPOSE
//  Streaming, parametrised XOR-fold compressor: each of NCH channels folds an IN_W-bit word to OUT_W bits
//  (XOR of all IN_W/OUT_W segments), optionally XOR-accumulating several beats into one output word.
//  Sits between a source of wide data words and a signature/hash consumer.
//  Replaces the fixed 2-channel 16->8 combinational fold with a registered valid/ready stage.
// PARAMETERS
//  NCH    2   number of independent channels
//  IN_W   16  input word width per channel; must be an integer multiple of OUT_W
//  OUT_W  8   folded output width per channel
//  CNT_W  8   width of the accumulate-length config and beat counter
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          reset, asynchronous, active-low
//  cfg_acc_en   in   1          0 = bypass (one output per input beat), 1 = accumulate
//  cfg_acc_len  in   CNT_W      beats per accumulated output; 0 is treated as 1
//  in_valid     in   1          input beat valid
//  in_ready     out  1          input beat accepted when in_valid & in_ready
//  in_data      in   NCH*IN_W   channel c occupies [c*IN_W +: IN_W]
//  in_last      in   1          closes the current accumulation early (ignored in bypass)
//  out_valid    out  1          output word valid
//  out_ready    in   1          consumer accepts when out_valid & out_ready
//  out_data     out  NCH*OUT_W  channel c occupies [c*OUT_W +: OUT_W]
//  out_cnt      out  CNT_W      number of input beats folded into out_data
//  busy         out  1          partial accumulation pending (state ACC)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_cnt=0, busy=0, accumulator=0, beat counter=0, state IDLE.
//  - fold(x) = XOR over k of x[k*OUT_W +: OUT_W], k = 0..IN_W/OUT_W-1; applied per channel.
//  - in_ready = !out_valid || out_ready (combinational; no dependence on in_valid or in_data).
//  - Config (cfg_acc_en, effective len) latched on the first accepted beat in IDLE; mid-frame changes ignored.
//  - Bypass: accepted beat -> out_data = fold(in_data), out_cnt = 1, out_valid next cycle (latency 1).
//  - Accumulate: beat closes frame if (count+1 == len) or in_last. Closing beat: out_data = acc ^ fold(in),
//    out_cnt = count+1, out_valid=1, acc<=0, count<=0, -> IDLE. Non-closing: acc ^= fold(in), count++, -> ACC.
//  - FSM: IDLE --non-closing beat--> ACC; ACC --closing beat--> IDLE; all other cycles hold.
//  - out_valid clears on out_ready with no new closing beat; accepted closing beat while draining reloads
//    out_data same edge (full throughput, one output per cycle).
//  - out_data/out_cnt stable while out_valid & !out_ready. No beat dropped or duplicated.
//  - len=1 or cfg_acc_en=0: every beat closes; state stays IDLE.
//  - count never exceeds latched len; no wrap. Async reset mid-frame discards partial acc and pending output.
// STRUCTURE
//  - Package xor_fold_pkg: state enum {IDLE, ACC}; function/localparam NSEG = IN_W/OUT_W;
//    elaboration check IN_W % OUT_W == 0.
//  - Sub-module xor_fold_seg (combinational, IN_W -> OUT_W), instantiated NCH times via generate.
//  - Top: FSM, accumulator, beat counter, config latch, output register.
// TESTING
//  - Bypass, NCH=2: in_data={16'h1234,16'hA55A} -> next cycle out_data=16'h26FF, out_cnt=1.
//  - Accumulate len=3, ch0 beats 16'h0102,16'h0408,16'h1020 -> one output ch0=8'h3F, out_cnt=3, busy low after.
//  - Same frame, in_last on beat 2 -> ch0=8'h0F, out_cnt=2; next beat starts new frame.
//  - out_ready held low 4 cycles with out_valid: in_ready=0, out_data stable; release -> back-to-back outputs.
//  - rst_n asserted mid-accumulation (count=2): outputs 0 immediately; next frame excludes old beats.
//  - IN_W=32,OUT_W=8: 32'h11223344 -> 8'h44; cfg_acc_len=0 behaves as 1.

Source files
------------

// File: rtl/xor_fold_pkg.sv
// Shared types and helpers for the XOR-fold stream compressor.
package xor_fold_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Number of OUT_W-wide segments in one IN_W-wide channel word.
  function automatic int unsigned nseg(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  // True when IN_W splits evenly into OUT_W-wide segments.
  function automatic bit width_ok(input int unsigned in_w, input int unsigned out_w);
    return (out_w != 0) && ((in_w % out_w) == 0);
  endfunction

endpackage

// File: rtl/xor_fold_stream_if.sv
// Valid/ready input and output streams of the XOR-fold compressor.
interface xor_fold_stream_if #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NCH*IN_W-1:0]    in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [NCH*OUT_W-1:0]   out_data;
  logic [CNT_W-1:0]       out_cnt;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
endinterface

// File: rtl/xor_fold_seg.sv
// Combinational fold of one IN_W-bit word down to OUT_W bits by XOR of its segments.
module xor_fold_seg
  import xor_fold_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);
  localparam int unsigned NSEG = nseg(IN_W, OUT_W);

  // XOR together every OUT_W-wide slice of the input word.
  always_comb begin
    dout = '0;
    for (int unsigned k = 0; k < NSEG; k++) begin
      dout = dout ^ din[k*OUT_W +: OUT_W];
    end
  end
endmodule

// File: rtl/xor_fold_stream.sv
// Registered valid/ready XOR-fold compressor with optional multi-beat accumulation.
module xor_fold_stream
  import xor_fold_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_acc_en,
  input  logic [CNT_W-1:0]   cfg_acc_len,
  xor_fold_stream_if.slave   bus,
  output logic               busy
);
  if (!width_ok(IN_W, OUT_W)) begin : g_bad_width
    $error("xor_fold_stream: IN_W must be a non-zero multiple of OUT_W");
  end

  state_t                 state;
  logic [NCH*OUT_W-1:0]   acc;
  logic [CNT_W-1:0]       cnt;
  logic                   lat_en;
  logic [CNT_W-1:0]       lat_len;
  logic                   out_valid_q;
  logic [NCH*OUT_W-1:0]   out_data_q;
  logic [CNT_W-1:0]       out_cnt_q;

  logic [NCH*OUT_W-1:0]   fold_w;
  logic                   accept;
  logic                   cur_en;
  logic [CNT_W-1:0]       cur_len;
  logic [CNT_W-1:0]       cfg_len_eff;
  logic [CNT_W:0]         cnt_inc;
  logic                   closing;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    xor_fold_seg #(.IN_W(IN_W), .OUT_W(OUT_W)) u_seg (
      .din  (bus.in_data[c*IN_W +: IN_W]),
      .dout (fold_w[c*OUT_W +: OUT_W])
    );
  end

  // Handshake and frame-closing decision; in IDLE the live config applies to the
  // first beat so a single-beat frame closes without waiting for the latch.
  always_comb begin
    bus.in_ready = !out_valid_q || bus.out_ready;
    accept       = bus.in_valid && bus.in_ready;
    cfg_len_eff  = (cfg_acc_len == '0) ? CNT_W'(1) : cfg_acc_len;
    cur_en       = (state == IDLE) ? cfg_acc_en  : lat_en;
    cur_len      = (state == IDLE) ? cfg_len_eff : lat_len;
    cnt_inc      = {1'b0, cnt} + (CNT_W+1)'(1);
    closing      = !cur_en || (cnt_inc == {1'b0, cur_len}) || bus.in_last;
  end

  // FSM, accumulator, beat counter, config latch and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      lat_en      <= 1'b0;
      lat_len     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (state == IDLE) begin
          lat_en  <= cfg_acc_en;
          lat_len <= cfg_len_eff;
        end
        if (closing) begin
          out_data_q  <= acc ^ fold_w;
          out_cnt_q   <= cnt_inc[CNT_W-1:0];
          out_valid_q <= 1'b1;
          acc         <= '0;
          cnt         <= '0;
          state       <= IDLE;
        end else begin
          acc   <= acc ^ fold_w;
          cnt   <= cnt_inc[CNT_W-1:0];
          state <= ACC;
        end
      end
    end
  end

  always_comb begin
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    bus.out_cnt   = out_cnt_q;
    busy          = (state == ACC);
  end
endmodule
